// File: rtl/game_pkg.sv
// Shared encodings and field layout for the game sequencer.
// Optional build macro: GODMODE_EN (hits pulse crash but never end the game).
package game_pkg;

    typedef enum logic [1:0] {
        MODE_INIT  = 2'b00,
        MODE_RUN   = 2'b01,
        MODE_PAUSE = 2'b10,
        MODE_END   = 2'b11
    } mode_t;

    localparam int NUM_OBS = 10;

    localparam int X_W = 10;
    localparam int Y_W = 9;

    // Per-slot packing: {right, left} in obstacle_x, {bottom, top} in obstacle_y
    localparam int X_SLOT      = 2 * X_W;
    localparam int Y_SLOT      = 2 * Y_W;
    localparam int X_LEFT_OFF  = 0;
    localparam int X_RIGHT_OFF = X_W;
    localparam int Y_TOP_OFF   = 0;
    localparam int Y_BOT_OFF   = Y_W;

endpackage

// File: rtl/box_overlap.sv
// Strict axis-aligned box intersection; box b is ignored when degenerate.
// All coordinates are compared at X_W bits so nothing wraps.
module box_overlap
    import game_pkg::*;
(
    input  logic [X_W-1:0] a_left,
    input  logic [X_W-1:0] a_right,
    input  logic [X_W-1:0] a_top,
    input  logic [X_W-1:0] a_bottom,
    input  logic [X_W-1:0] b_left,
    input  logic [X_W-1:0] b_right,
    input  logic [X_W-1:0] b_top,
    input  logic [X_W-1:0] b_bottom,
    output logic           hit
);

    logic b_active;
    logic x_hit;
    logic y_hit;

    assign b_active = (b_left < b_right) && (b_top < b_bottom);
    assign x_hit    = (b_left < a_right) && (b_right > a_left);
    assign y_hit    = (b_top < a_bottom) && (b_bottom > a_top);
    assign hit      = b_active && x_hit && y_hit;

endmodule

// File: rtl/game_ctrl.sv
// Game-mode FSM and per-frame obstacle scan, one slot per cycle.
// Build macro GODMODE_EN: a hit pulses crash but the game keeps running.
module game_ctrl
    import game_pkg::*;
#(
    parameter int NUM_OBS     = game_pkg::NUM_OBS,
    parameter int PLAYER_X    = 100,
    parameter int PLAYER_SIZE = 40,
    parameter int SCORE_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   pause,
    input  logic                   frame_tick,
    input  logic [Y_W-1:0]         player_y,
    input  logic [20*NUM_OBS-1:0]  obstacle_x,
    input  logic [18*NUM_OBS-1:0]  obstacle_y,
    output logic [1:0]             gamemode,
    output logic                   update_en,
    output logic                   crash,
    output logic [SCORE_W-1:0]     score,
    output logic                   busy
);

    localparam int IDX_W = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OBS - 1);
    localparam logic [X_W-1:0] P_LEFT  = X_W'(PLAYER_X);
    localparam logic [X_W-1:0] P_RIGHT = X_W'(PLAYER_X + PLAYER_SIZE);
    localparam logic [X_W-1:0] P_SIZE  = X_W'(PLAYER_SIZE);

    mode_t              state_q, state_d;
    logic               busy_q, busy_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               hit_q, hit_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               upd_q, upd_d;
    logic               crash_q, crash_d;

    logic [X_W-1:0] sl_left  [NUM_OBS];
    logic [X_W-1:0] sl_right [NUM_OBS];
    logic [X_W-1:0] sl_top   [NUM_OBS];
    logic [X_W-1:0] sl_bot   [NUM_OBS];

    for (genvar i = 0; i < NUM_OBS; i++) begin : g_slot
        assign sl_left[i]  = obstacle_x[i*X_SLOT+X_LEFT_OFF +: X_W];
        assign sl_right[i] = obstacle_x[i*X_SLOT+X_RIGHT_OFF +: X_W];
        assign sl_top[i]   = {1'b0, obstacle_y[i*Y_SLOT+Y_TOP_OFF +: Y_W]};
        assign sl_bot[i]   = {1'b0, obstacle_y[i*Y_SLOT+Y_BOT_OFF +: Y_W]};
    end

    logic [X_W-1:0] p_top;
    logic [X_W-1:0] p_bot;
    logic           slot_hit;
    logic           frame_hit;

    assign p_top = {1'b0, player_y};
    assign p_bot = p_top + P_SIZE;

    box_overlap u_overlap (
        .a_left   (P_LEFT),
        .a_right  (P_RIGHT),
        .a_top    (p_top),
        .a_bottom (p_bot),
        .b_left   (sl_left[idx_q]),
        .b_right  (sl_right[idx_q]),
        .b_top    (sl_top[idx_q]),
        .b_bottom (sl_bot[idx_q]),
        .hit      (slot_hit)
    );

    assign frame_hit = hit_q | slot_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MODE_INIT;
            busy_q  <= 1'b0;
            idx_q   <= '0;
            hit_q   <= 1'b0;
            score_q <= '0;
            upd_q   <= 1'b0;
            crash_q <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            idx_q   <= idx_d;
            hit_q   <= hit_d;
            score_q <= score_d;
            upd_q   <= upd_d;
            crash_q <= crash_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        idx_d   = idx_q;
        hit_d   = hit_q;
        score_d = score_q;
        upd_d   = 1'b0;
        crash_d = 1'b0;
        unique case (state_q)
            MODE_INIT: begin
                busy_d  = 1'b0;
                idx_d   = '0;
                hit_d   = 1'b0;
                score_d = '0;
                if (start) state_d = MODE_RUN;
            end
            MODE_RUN: begin
                if (!start) begin
                    state_d = MODE_INIT;
                    busy_d  = 1'b0;
                    idx_d   = '0;
                    hit_d   = 1'b0;
                    score_d = '0;
                end else if (busy_q) begin
                    hit_d = frame_hit;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        busy_d = 1'b0;
                        idx_d  = '0;
                        hit_d  = 1'b0;
                        if (frame_hit) begin
                            crash_d = 1'b1;
`ifdef GODMODE_EN
                            state_d = MODE_RUN;
`else
                            state_d = MODE_END;
`endif
                        end else begin
                            upd_d   = 1'b1;
                            score_d = (&score_q) ? score_q : score_q + 1'b1;
                        end
                    end
                end else if (pause) begin
                    state_d = MODE_PAUSE;
                end else if (frame_tick) begin
                    busy_d = 1'b1;
                    idx_d  = '0;
                    hit_d  = 1'b0;
                end
            end
            MODE_PAUSE: begin
                if (!start) begin
                    state_d = MODE_INIT;
                    score_d = '0;
                end else if (!pause) begin
                    state_d = MODE_RUN;
                end
            end
            MODE_END: begin
                if (!start) begin
                    state_d = MODE_INIT;
                    score_d = '0;
                end
            end
        endcase
    end

    assign gamemode  = state_q;
    assign update_en = upd_q;
    assign crash     = crash_q;
    assign score     = score_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: overlap vector table plus mode sequences.
module tb_game_ctrl;

    localparam int NO = 10;
`ifdef GODMODE_EN
    localparam bit GOD = 1'b1;
`else
    localparam bit GOD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            pause;
    logic            frame_tick;
    logic [8:0]      player_y;
    logic [20*NO-1:0] obstacle_x;
    logic [18*NO-1:0] obstacle_y;
    logic [1:0]      gamemode;
    logic            update_en;
    logic            crash;
    logic [15:0]     score;
    logic            busy;

    always #5 clk = ~clk;

    game_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pause      (pause),
        .frame_tick (frame_tick),
        .player_y   (player_y),
        .obstacle_x (obstacle_x),
        .obstacle_y (obstacle_y),
        .gamemode   (gamemode),
        .update_en  (update_en),
        .crash      (crash),
        .score      (score),
        .busy       (busy)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_slots();
        obstacle_x = '0;
        obstacle_y = '0;
    endtask

    task automatic set_slot(input int i, input int l, input int r,
                            input int t, input int b);
        obstacle_x[20*i +: 10]    = 10'(l);
        obstacle_x[20*i+10 +: 10] = 10'(r);
        obstacle_y[18*i +: 9]     = 9'(t);
        obstacle_y[18*i+9 +: 9]   = 9'(b);
    endtask

    // tick at cycle t, return positioned in result cycle t+11
    task automatic run_frame();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step(10);
    endtask

    task automatic restart();
        start = 1'b0;
        step();
        start = 1'b1;
        step();
    endtask

    typedef struct {
        int   slot;
        int   l;
        int   r;
        int   t;
        int   b;
        int   py;
        logic hit;
    } vec_t;

    vec_t vecs[11];
    logic seen;

    initial begin
        vecs[0]  = '{-1,    0,    0,   0,   0, 210, 1'b0};
        vecs[1]  = '{ 7,   90,  130, 200, 240, 210, 1'b1};
        vecs[2]  = '{ 0,  140,  180, 200, 240, 210, 1'b0};
        vecs[3]  = '{ 0,   60,  100, 200, 240, 210, 1'b0};
        vecs[4]  = '{ 9,  139,  150, 249, 260, 210, 1'b1};
        vecs[5]  = '{ 3,   90,  130, 250, 260, 210, 1'b0};
        vecs[6]  = '{ 5,  130,   90, 200, 240, 210, 1'b0};
        vecs[7]  = '{ 2,   90,  130, 240, 200, 210, 1'b0};
        vecs[8]  = '{ 4,  100,  140, 510, 511, 500, 1'b1};
        vecs[9]  = '{ 6, 1000, 1023, 200, 240, 210, 1'b0};
        vecs[10] = '{ 0,   95,  105, 205, 215, 210, 1'b1};

        rst        = 1'b1;
        start      = 1'b0;
        pause      = 1'b0;
        frame_tick = 1'b0;
        player_y   = 9'd210;
        clear_slots();
        step(2);
        rst = 1'b0;
        chk("rst_mode", gamemode, 0);
        chk("rst_busy", busy, 0);
        chk("rst_upd", update_en, 0);
        chk("rst_crash", crash, 0);
        chk("rst_score", score, 0);
        step();
        chk("init_hold", gamemode, 0);
        start = 1'b1;
        step();
        chk("init_to_run", gamemode, 1);

        // clean frame, with a tick dropped while busy
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("busy_t1", busy, 1);
        step(8);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("busy_t10", busy, 1);
        chk("upd_t10", update_en, 0);
        step();
        chk("upd_t11", update_en, 1);
        chk("busy_t11", busy, 0);
        chk("score_1", score, 1);
        step();
        chk("upd_t12", update_en, 0);
        chk("drop_tick", busy, 0);
        for (int k = 0; k < 3; k++) run_frame();
        chk("score_4", score, 4);

        // pause requested mid-scan
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step(4);
        pause = 1'b1;
        step(6);
        chk("pause_upd", update_en, 1);
        chk("pause_mode_t11", gamemode, 1);
        step();
        chk("pause_mode_t12", gamemode, 2);
        seen = 1'b0;
        frame_tick = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            frame_tick = 1'b0;
            seen = seen | busy | update_en;
        end
        chk("pause_ignores_tick", seen, 0);
        chk("pause_score", score, 5);
        pause = 1'b0;
        step();
        chk("unpause_mode", gamemode, 1);

        // start dropped mid-scan
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step(3);
        start = 1'b0;
        step();
        chk("abort_mode", gamemode, 0);
        chk("abort_busy", busy, 0);
        chk("abort_score", score, 0);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            seen = seen | update_en | busy;
        end
        chk("abort_no_upd", seen, 0);
        start = 1'b1;
        step();

        // overlap table
        for (int v = 0; v < 11; v++) begin
            clear_slots();
            if (vecs[v].slot >= 0)
                set_slot(vecs[v].slot, vecs[v].l, vecs[v].r,
                         vecs[v].t, vecs[v].b);
            player_y = 9'(vecs[v].py);
            restart();
            run_frame();
            chk($sformatf("vec%0d_upd", v), update_en, !vecs[v].hit);
            chk($sformatf("vec%0d_crash", v), crash, vecs[v].hit);
            chk($sformatf("vec%0d_mode", v), gamemode,
                (vecs[v].hit && !GOD) ? 3 : 1);
        end

        // hit after a clean frame: score held, END holds
        clear_slots();
        player_y = 9'd210;
        restart();
        run_frame();
        chk("end_pre_score", score, 1);
        set_slot(7, 90, 130, 200, 240);
        run_frame();
        chk("end_crash", crash, 1);
        chk("end_upd", update_en, 0);
        chk("end_mode", gamemode, GOD ? 1 : 3);
        chk("end_score", score, 1);
        step();
        chk("crash_pulse", crash, 0);
        if (!GOD) begin
            run_frame();
            step();
            chk("end_hold_mode", gamemode, 3);
            chk("end_hold_score", score, 1);
            chk("end_hold_busy", busy, 0);
            start = 1'b0;
            step();
            chk("end_to_init", gamemode, 0);
            chk("end_init_score", score, 0);
        end else begin
            clear_slots();
            run_frame();
            chk("god_next_upd", update_en, 1);
            chk("god_next_score", score, 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Top-level game sequencer sitting between the VGA frame timer and the player/obstacle datapath.
- Owns the game-mode FSM (initial / in-game / paused / ended).
- Once per frame it scans all obstacle boxes against the player box, one per cycle.
- After the scan it either issues a one-cycle update strobe that advances the datapath and score, or ends the game on collision.

Parameters:
- NUM_OBS, 10, number of obstacle slots scanned per frame.
- PLAYER_X, 100, fixed left x of the player box, in pixels.
- PLAYER_SIZE, 40, player box width and height, in pixels.
- SCORE_W, 16, score counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level; 1 = game enabled, 0 = return to initial.
- pause  in  1  level; 1 = request pause.
- frame_tick  in  1  one-cycle pulse per video frame.
- player_y  in  9  player box top y.
- obstacle_x  in  20*NUM_OBS  slot i: [20i+9:20i] = left x, [20i+19:20i+10] = right x (exclusive).
- obstacle_y  in  18*NUM_OBS  slot i: [18i+8:18i] = top y, [18i+17:18i+9] = bottom y (exclusive).
- gamemode  out  2  00 = initial, 01 = in-game, 10 = paused, 11 = ended.
- update_en  out  1  one-cycle strobe: datapath advances one frame.
- crash  out  1  one-cycle pulse on a detected hit.
- score  out  SCORE_W  frames survived.
- busy  out  1  scan in progress.

Behaviour:
- Reset: gamemode=00, update_en=0, crash=0, score=0, busy=0, scan index=0. Reset overrides everything else.
- FSM states and transitions:
  - INIT(00): stays while start=0; start=1 → RUN next cycle; score cleared on entry.
  - RUN(01): start=0 → INIT (any in-flight scan aborted, busy=0). pause=1 with busy=0 → PAUSE. pause=1 during a scan → PAUSE in the cycle after the scan result.
  - PAUSE(10): pause=0 → RUN; start=0 → INIT. frame_tick is ignored.
  - END(11): hold, with score frozen, until start=0 → INIT.
- Scan sequence:
  - frame_tick sampled high in RUN with busy=0 at cycle t sets busy=1 from t+1.
  - Cycles t+1..t+NUM_OBS compare slot idx=0..NUM_OBS-1, one slot per cycle; a sticky hit flag accumulates.
  - Result cycle t+NUM_OBS+1: busy=0.
    - No hit: update_en=1 for one cycle, and score increments, saturating at all-ones.
    - Hit: crash=1 for one cycle, gamemode=11 from that cycle, update_en stays 0.
- frame_tick during busy=1 or outside RUN is dropped, not queued.
- Overlap test is strict and performed at 10-bit width, with no wrap:
  - x: left < PLAYER_X+PLAYER_SIZE AND right > PLAYER_X.
  - y: top < player_y+PLAYER_SIZE AND bottom > player_y.
  - Boxes that merely touch do not hit.
- A slot with left >= right or top >= bottom is inactive and never hits.
- Inputs are sampled on the compare cycle only. The datapath changes only on update_en, so inputs are stable for the whole scan.
- start and pause are level inputs and are expected to be pre-synchronised and debounced.

Optional Feature:
- Macro GODMODE_EN.
- Defined: a hit still pulses crash, but never enters END. That frame produces no update_en and no score increment, and the next frame scans normally.
- Undefined: a hit ends the game as described under Behaviour.

Decomposition:
- game_pkg holds:
  - gamemode encodings MODE_INIT/MODE_RUN/MODE_PAUSE/MODE_END;
  - NUM_OBS;
  - field widths X_W=10 and Y_W=9;
  - slot bit offsets for obstacle_x and obstacle_y.
- One combinational sub-module, box_overlap, takes two boxes (left/right/top/bottom) and returns hit. It includes the inactive-slot check.

Test Plan:
- Reset, then start=1 → gamemode 00→01 next cycle. With no obstacles (all zero), a tick at t gives update_en at t+11, score=1. Three more ticks give score=4.
- Slot 7 = x[90,130) y[200,240), player_y=210 → crash at t+11, gamemode=11, no update_en, score held.
- Slot 0 left=140 (touching the player's right edge at 140) → no hit; update_en at t+11.
- pause=1 at t+5 mid-scan → update_en at t+11, gamemode=10 at t+12. Ticks in PAUSE are ignored. pause=0 → 01.
- start=0 at t+4 mid-scan → gamemode=00 next cycle, busy=0, score=0, no update_en.
- GODMODE_EN with the hit case → crash pulse, gamemode stays 01, score unchanged. The next clean tick gives update_en.
